// File: rtl/cache_cmd_controller.sv
// Command sequencer in front of the cache memory block: expands GET/PUT/DEL requests into
// single-cycle read/delete/write strobes, returns value/hit/error and tracks occupancy.
module cache_cmd_controller #(
  parameter  int NUM_ENTRIES = 16,
  parameter  int KEY_WIDTH   = 16,
  parameter  int VALUE_WIDTH = 64,
  localparam int CNT_WIDTH   = $clog2(NUM_ENTRIES + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [1:0]             req_op,
  input  logic [KEY_WIDTH-1:0]   req_key,
  input  logic [VALUE_WIDTH-1:0] req_value,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [VALUE_WIDTH-1:0] resp_value,
  output logic                   resp_hit,
  output logic                   resp_err,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic                   mem_delete,
  output logic [KEY_WIDTH-1:0]   mem_key,
  output logic [VALUE_WIDTH-1:0] mem_value,
  input  logic [VALUE_WIDTH-1:0] mem_rd_value,
  input  logic                   mem_hit,
  output logic [CNT_WIDTH-1:0]   occupancy,
  output logic                   full
);

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_DELETE, S_WRITE, S_RESP} state_t;
  typedef enum logic [1:0] {OP_GET = 2'b00, OP_PUT = 2'b01, OP_DEL = 2'b10, OP_RSV = 2'b11} op_t;

  state_t                 r_state, w_next;
  op_t                    r_op;
  logic [KEY_WIDTH-1:0]   r_key;
  logic [VALUE_WIDTH-1:0] r_value;
  logic [VALUE_WIDTH-1:0] r_resp_value;
  logic                   r_resp_hit;
  logic                   r_resp_err;
  logic [CNT_WIDTH-1:0]   r_occ;
  logic                   w_full;
  logic                   w_accept;

  assign w_full   = (r_occ == CNT_WIDTH'(NUM_ENTRIES));
  assign w_accept = (r_state == S_IDLE) && req_valid;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_next     = r_state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_delete = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = (op_t'(req_op) == OP_RSV) ? S_RESP : S_LOOKUP;
      end
      S_LOOKUP: begin
        mem_read = 1'b1;
        case (r_op)
          OP_PUT:  w_next = mem_hit ? S_DELETE : (w_full ? S_RESP : S_WRITE);
          OP_DEL:  w_next = mem_hit ? S_DELETE : S_RESP;
          default: w_next = S_RESP;
        endcase
      end
      S_DELETE: begin
        mem_delete = 1'b1;
        w_next     = (r_op == OP_PUT) ? S_WRITE : S_RESP;
      end
      S_WRITE: begin
        mem_write = 1'b1;
        w_next    = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Request copy, response fields and occupancy; the response is built while the FSM walks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op         <= OP_GET;
      r_key        <= '0;
      r_value      <= '0;
      r_resp_value <= '0;
      r_resp_hit   <= 1'b0;
      r_resp_err   <= 1'b0;
      r_occ        <= '0;
    end else begin
      if (w_accept) begin
        r_op         <= op_t'(req_op);
        r_key        <= req_key;
        r_value      <= req_value;
        r_resp_value <= '0;
        r_resp_hit   <= 1'b0;
        r_resp_err   <= (op_t'(req_op) == OP_RSV);
      end
      if (r_state == S_LOOKUP) begin
        r_resp_hit <= mem_hit;
        if (r_op == OP_GET && mem_hit)              r_resp_value <= mem_rd_value;
        if (r_op == OP_PUT && !mem_hit && w_full)   r_resp_err   <= 1'b1;
      end
      if (r_state == S_DELETE && r_occ != '0)       r_occ <= r_occ - CNT_WIDTH'(1);
      if (r_state == S_WRITE && !w_full)            r_occ <= r_occ + CNT_WIDTH'(1);
    end
  end

  // The memory bus idles at zero and carries the captured request while a command is in flight.
  assign mem_key    = (r_state != S_IDLE) ? r_key   : '0;
  assign mem_value  = (r_state != S_IDLE) ? r_value : '0;
  assign resp_value = r_resp_value;
  assign resp_hit   = r_resp_hit;
  assign resp_err   = r_resp_err;
  assign occupancy  = r_occ;
  assign full       = w_full;

  a_no_delete_when_empty: assert property (@(posedge clk) disable iff (!rst_n)
    (r_state == S_DELETE) |-> (r_occ != '0))
    else $error("delete issued with occupancy 0");

endmodule
